// File: rtl/palette_pkg.sv
// Shared types and constants for the palette mapper.
//   rgb_t          : 8-bit-per-channel colour triple
//   colour consts  : 8-bit power-on palette colours
//   default_entry  : power-on colour for an index, each lane right-aligned
//                    to ch_w bits (top ch_w bits of the 8-bit colour)
//   fade_state_t   : fade controller states
package palette_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t BLACK        = 24'h000000;
    localparam rgb_t PLAYER1      = 24'h00688B;
    localparam rgb_t PLAYER2      = 24'hFF7F50;
    localparam rgb_t GROUND       = 24'hAABB11;
    localparam rgb_t BG_LEFT      = 24'h4F6898;
    localparam rgb_t BG_RIGHT     = 24'hE84A27;
    localparam rgb_t HP_DEPLETED  = 24'h13294B;
    localparam rgb_t HP           = 24'hDC143C;
    localparam rgb_t ACCENT       = 24'h13FF7F;
    localparam rgb_t DEFAULT_FILL = 24'hFFD3BA;

    typedef enum logic {
        IDLE,
        FADING
    } fade_state_t;

    // Each 8-bit lane is shifted right so its low ch_w bits hold the
    // truncated channel value.
    function automatic logic [23:0] default_entry(input int unsigned idx,
                                                  input int unsigned ch_w);
        rgb_t c;
        int unsigned s;
        case (idx)
            0, 1, 2, 3: c = BLACK;
            4:          c = PLAYER1;
            5:          c = PLAYER2;
            8:          c = GROUND;
            59:         c = BG_LEFT;
            60:         c = BG_RIGHT;
            61:         c = HP_DEPLETED;
            62:         c = HP;
            63:         c = ACCENT;
            default:    c = DEFAULT_FILL;
        endcase
        s = 8 - ch_w;
        return {c.r >> s, c.g >> s, c.b >> s};
    endfunction

endpackage

// File: rtl/palette_mapper_fade_ctrl.sv
// Frame-synchronous brightness fade controller.
//   Clk, Reset_n  : pixel clock, async active-low reset
//   frame_clk     : vsync-rate level; rising edge = frame tick
//   fade_start    : one-cycle request, fade_dir 0 = out, 1 = in
//   level         : brightness L, 0..2**FADE_W
//   fade_busy     : high while a fade is running
//
// state  | meaning
// IDLE   | L held; waiting for fade_start
// FADING | stepping L one unit every FRAMES_PER_STEP frame ticks
module palette_mapper_fade_ctrl
    import palette_pkg::*;
#(
    parameter int FADE_W          = 4,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            frame_clk,
    input  logic            fade_start,
    input  logic            fade_dir,
    output logic [FADE_W:0] level,
    output logic            fade_busy
);

    localparam int CNT_W = $clog2(FRAMES_PER_STEP + 1);
    localparam logic [FADE_W:0] FADE_MAX = (FADE_W + 1)'(2 ** FADE_W);
    localparam logic [CNT_W-1:0] STEP_TC = CNT_W'(FRAMES_PER_STEP);

    fade_state_t      state, state_n;
    logic             frame_clk_q;
    logic             dir_q, dir_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [FADE_W:0]  level_n;
    logic             tick;

    assign tick      = frame_clk & ~frame_clk_q;
    assign fade_busy = (state == FADING);

    // frame_clk_q resets high so a frame_clk already high at release is not a tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            frame_clk_q <= 1'b1;
            dir_q       <= 1'b0;
            cnt         <= '0;
            level       <= FADE_MAX;
        end else begin
            state       <= state_n;
            frame_clk_q <= frame_clk;
            dir_q       <= dir_n;
            cnt         <= cnt_n;
            level       <= level_n;
        end
    end

    always_comb begin
        state_n = state;
        dir_n   = dir_q;
        cnt_n   = cnt;
        level_n = level;
        case (state)
            IDLE: begin
                if (fade_start) begin
                    dir_n = fade_dir;
                    cnt_n = '0;
                    if (level != (fade_dir ? FADE_MAX : '0)) begin
                        state_n = FADING;
                    end
                end
            end
            FADING: begin
                if (tick) begin
                    if (cnt + CNT_W'(1) == STEP_TC) begin
                        cnt_n   = '0;
                        level_n = dir_q ? level + (FADE_W + 1)'(1)
                                        : level - (FADE_W + 1)'(1);
                        if (level_n == (dir_q ? FADE_MAX : '0)) begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: rtl/palette_mapper.sv
// Colour index to RGB mapper with writable palette and brightness fade.
//   Clk, Reset_n          : pixel clock, async active-low reset
//   color, pix_valid      : per-pixel index and active-video flag
//   pal_we/addr/wdata     : palette write port, wdata = {R,G,B}
//   frame_clk             : vsync-rate level (rising edge = frame tick)
//   fade_start, fade_dir  : fade request (0 = to black, 1 = to full)
//   fade_busy             : fade in progress
//   out_valid, VGA_R/G/B  : RGB output, two cycles after the input pixel
module palette_mapper
    import palette_pkg::*;
#(
    parameter int IDX_W           = 6,
    parameter int CH_W            = 8,
    parameter int FADE_W          = 4,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [IDX_W-1:0]  color,
    input  logic              pix_valid,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_addr,
    input  logic [3*CH_W-1:0] pal_wdata,
    input  logic              frame_clk,
    input  logic              fade_start,
    input  logic              fade_dir,
    output logic              fade_busy,
    output logic              out_valid,
    output logic [CH_W-1:0]   VGA_R,
    output logic [CH_W-1:0]   VGA_G,
    output logic [CH_W-1:0]   VGA_B
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int PW    = CH_W + FADE_W + 1;

    logic [3*CH_W-1:0] pal [DEPTH];
    logic [IDX_W-1:0]  idx_q;
    logic              vld_q;
    logic [3*CH_W-1:0] entry;
    logic [FADE_W:0]   level;

    function automatic logic [3*CH_W-1:0] reset_entry(input int unsigned idx);
        logic [23:0] d;
        d = default_entry(idx, CH_W);
        return {d[16 +: CH_W], d[8 +: CH_W], d[0 +: CH_W]};
    endfunction

    function automatic logic [CH_W-1:0] scale(input logic [CH_W-1:0] ch,
                                              input logic [FADE_W:0] lv);
        return CH_W'((PW'(ch) * PW'(lv)) >> FADE_W);
    endfunction

    palette_mapper_fade_ctrl #(
        .FADE_W          (FADE_W),
        .FRAMES_PER_STEP (FRAMES_PER_STEP)
    ) u_fade (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .frame_clk  (frame_clk),
        .fade_start (fade_start),
        .fade_dir   (fade_dir),
        .level      (level),
        .fade_busy  (fade_busy)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pal[IDX_W'(i)] <= reset_entry(i);
            end
        end else if (pal_we) begin
            pal[pal_addr] <= pal_wdata;
        end
    end

    // Read of registered palette state: a write landing on the same edge
    // that registers the output leaves this pixel with the old entry.
    assign entry = pal[idx_q];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            idx_q     <= '0;
            vld_q     <= 1'b0;
            out_valid <= 1'b0;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
        end else begin
            idx_q     <= color;
            vld_q     <= pix_valid;
            out_valid <= vld_q;
            if (vld_q) begin
                VGA_R <= scale(entry[2*CH_W +: CH_W], level);
                VGA_G <= scale(entry[CH_W +: CH_W], level);
                VGA_B <= scale(entry[0 +: CH_W], level);
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
        end
    end

endmodule

// File: tb/tb_palette_mapper.sv
module tb_palette_mapper;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [5:0]  color;
    logic        pix_valid;
    logic        pal_we;
    logic [5:0]  pal_addr;
    logic [23:0] pal_wdata;
    logic        frame_clk;
    logic        fade_start;
    logic        fade_dir;
    logic        fade_busy;
    logic        out_valid;
    logic [7:0]  VGA_R, VGA_G, VGA_B;

    always #5 Clk = ~Clk;

    palette_mapper #(
        .IDX_W           (6),
        .CH_W            (8),
        .FADE_W          (4),
        .FRAMES_PER_STEP (1)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .color      (color),
        .pix_valid  (pix_valid),
        .pal_we     (pal_we),
        .pal_addr   (pal_addr),
        .pal_wdata  (pal_wdata),
        .frame_clk  (frame_clk),
        .fade_start (fade_start),
        .fade_dir   (fade_dir),
        .fade_busy  (fade_busy),
        .out_valid  (out_valid),
        .VGA_R      (VGA_R),
        .VGA_G      (VGA_G),
        .VGA_B      (VGA_B)
    );

    typedef struct {
        int          due;
        logic [24:0] exp;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: an expected entry is due exactly two cycles after issue.
    always @(negedge Clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
            e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: output never compared at cycle %0d", e.tag, e.due);
        end
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk(e.tag, {7'b0, out_valid, VGA_R, VGA_G, VGA_B}, {7'b0, e.exp});
        end else if (out_valid === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel: got valid rgb %h expected none (cycle %0d)",
                     {VGA_R, VGA_G, VGA_B}, cyc);
        end
    end

    task automatic nxt();
        @(posedge Clk);
        #1;
        pix_valid  = 1'b0;
        pal_we     = 1'b0;
        fade_start = 1'b0;
    endtask

    task automatic pix(input logic [5:0] c, input logic v, input logic [23:0] rgb,
                       input string tag);
        exp_t e;
        color     = c;
        pix_valid = v;
        e.due = cyc + 2;
        e.exp = v ? {1'b1, rgb} : 25'h0;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic wr(input logic [5:0] a, input logic [23:0] d);
        pal_we    = 1'b1;
        pal_addr  = a;
        pal_wdata = d;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            nxt();
            frame_clk = 1'b1;
            nxt();
            frame_clk = 1'b0;
        end
    endtask

    task automatic drain();
        repeat (3) nxt();
    endtask

    initial begin
        Reset_n    = 1'b0;
        color      = 6'd4;
        pix_valid  = 1'b1;
        pal_we     = 1'b0;
        pal_addr   = '0;
        pal_wdata  = '0;
        frame_clk  = 1'b0;
        fade_start = 1'b0;
        fade_dir   = 1'b0;

        #12;
        chk("reset_rgb", {7'b0, out_valid, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("reset_busy", {31'b0, fade_busy}, 32'h0);

        // Defaults and latency
        #10;
        Reset_n = 1'b1;
        pix(6'd4, 1'b1, 24'h00688B, "idx4_first");
        nxt(); pix(6'd4,  1'b1, 24'h00688B, "idx4_held");
        nxt(); pix(6'd13, 1'b1, 24'hFFD3BA, "idx13_fill");
        nxt(); pix(6'd8,  1'b1, 24'hAABB11, "idx8");
        nxt(); pix(6'd62, 1'b1, 24'hDC143C, "idx62");
        nxt(); pix(6'd0,  1'b1, 24'h000000, "idx0_black");
        drain();

        // Blanking
        nxt(); pix(6'd63, 1'b0, 24'h0, "blank63");
        for (int i = 0; i < 6; i++) begin
            nxt(); pix(6'd63, (i % 2) == 0, 24'h13FF7F, "toggle63");
        end
        drain();

        // Palette writes
        nxt(); wr(6'd5, 24'h123456);
        nxt(); pix(6'd5, 1'b1, 24'h123456, "write_new");
        drain();
        nxt(); wr(6'd5, 24'hFF7F50);
        nxt(); pix(6'd5, 1'b1, 24'hFF7F50, "same_cycle_old");
        nxt(); wr(6'd5, 24'h123456); pix(6'd5, 1'b1, 24'h123456, "same_cycle_next");
        nxt(); pix(6'd5, 1'b1, 24'h123456, "write_held");
        drain();
        nxt(); wr(6'd5, 24'hFF7F50);
        drain();

        // Fade out, with an ignored restart mid-fade
        nxt(); fade_start = 1'b1; fade_dir = 1'b0;
        nxt(); nxt();
        chk("fade_out_busy", {31'b0, fade_busy}, 32'h1);
        ticks(4);
        nxt(); fade_start = 1'b1; fade_dir = 1'b1;
        ticks(4);
        nxt(); pix(6'd5, 1'b1, 24'h7F3F28, "fade_L8");
        drain();
        ticks(7);
        chk("fade_busy_L1", {31'b0, fade_busy}, 32'h1);
        ticks(1);
        chk("fade_busy_drop", {31'b0, fade_busy}, 32'h0);
        nxt(); pix(6'd5, 1'b1, 24'h000000, "fade_L0");
        drain();

        // Fade in
        nxt(); fade_start = 1'b1; fade_dir = 1'b1;
        nxt();
        chk("fade_in_busy", {31'b0, fade_busy}, 32'h1);
        ticks(4);
        nxt(); pix(6'd5, 1'b1, 24'h3F1F14, "fade_L4");
        drain();
        ticks(12);
        chk("fade_in_done", {31'b0, fade_busy}, 32'h0);
        nxt(); pix(6'd5, 1'b1, 24'hFF7F50, "fade_full");
        drain();
        nxt(); fade_start = 1'b1; fade_dir = 1'b1;
        nxt();
        chk("noop_busy_a", {31'b0, fade_busy}, 32'h0);
        nxt();
        chk("noop_busy_b", {31'b0, fade_busy}, 32'h0);

        // Reset mid-fade
        nxt(); wr(6'd5, 24'h123456);
        nxt(); fade_start = 1'b1; fade_dir = 1'b0;
        nxt();
        ticks(11);
        nxt(); pix(6'd5, 1'b1, 24'h05101A, "fade_L5_a");
        nxt(); pix(6'd5, 1'b1, 24'h05101A, "fade_L5_b");
        nxt();
        @(posedge Clk);
        #7;
        frame_clk = 1'b1;
        Reset_n   = 1'b0;
        #1;
        chk("midfade_rst_rgb", {7'b0, out_valid, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("midfade_rst_busy", {31'b0, fade_busy}, 32'h0);
        #1;
        Reset_n = 1'b1;
        nxt(); pix(6'd5, 1'b1, 24'hFF7F50, "post_reset_default");
        drain();
        nxt(); fade_start = 1'b1; fade_dir = 1'b0;
        repeat (4) nxt();
        pix(6'd5, 1'b1, 24'hFF7F50, "held_frame_clk_no_step");
        nxt();
        frame_clk = 1'b0;
        drain();

        for (int i = 0; i < 10; i++) begin
            if (sbq.size() == 0) break;
            nxt();
        end
        chk("scoreboard_empty", sbq.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/palette_mapper.md
Name: palette_mapper

Overview:
Successor to the fixed-case colour mapper. It converts a per-pixel colour index into RGB through a writable palette held in registers, with parametrised index and channel widths. A frame-synchronous brightness fade engine supports KO and round-transition fades, and blanking is handled inside the block. It sits between the sprite/priority logic and the VGA RGB pins, clocked by the pixel clock.

Parameters:
IDX_W, 6, colour index width; palette depth DEPTH = 2**IDX_W.
CH_W, 8, per-channel output width; legal range 4..8.
FADE_W, 4, fade level resolution; FADE_MAX = 2**FADE_W.
FRAMES_PER_STEP, 2, frame ticks per fade level step (>=1).

Ports:
Clk  in  1  pixel clock
Reset_n  in  1  asynchronous active-low reset
color  in  IDX_W  colour index for the current pixel
pix_valid  in  1  1 = active video; 0 = blank
pal_we  in  1  palette write strobe
pal_addr  in  IDX_W  palette write address
pal_wdata  in  3*CH_W  {R,G,B} write data
frame_clk  in  1  vsync-rate signal (Clk domain); its rising edge is the frame tick
fade_start  in  1  one-cycle fade request
fade_dir  in  1  0 = fade out to black, 1 = fade in to full
fade_busy  out  1  fade in progress
out_valid  out  1  pix_valid delayed to align with RGB
VGA_R, VGA_G, VGA_B  out  CH_W each  RGB output

Behaviour:
- Reset (async, Reset_n=0):
  - Palette loads defaults; each default is an 8-bit value truncated to its top CH_W bits.
  - Defaults: idx 0-3 000000, 4 00688B, 5 FF7F50, 8 AABB11, 59 4F6898, 60 E84A27, 61 13294B, 62 DC143C, 63 13FF7F. All other indices (including those >=64) FFD3BA.
  - VGA_* = 0, out_valid = 0, fade_busy = 0, level L = FADE_MAX, FSM = IDLE, frame_clk_q = 1 (suppresses a spurious tick if frame_clk is high at reset release).
- Pipeline, latency 2:
  - Cycle 1 registers color and pix_valid.
  - Cycle 2 reads the palette at the registered index, scales by L, and registers VGA_* and out_valid.
  - Accepts one pixel per cycle, no stalls.
- Blank: if the stage-1 valid bit is 0, VGA_* = 0 and out_valid = 0 regardless of index.
- Scaling:
  - ch_out = (entry_ch * L) >> FADE_W, with a product width of CH_W+FADE_W+1.
  - L = FADE_MAX gives an exact pass-through; L = 0 gives black.
- Palette write:
  - Accepted every cycle pal_we = 1; entry updates at that clock edge.
  - A lookup whose palette read occurs in the same cycle as a write to the same address returns the OLD entry. Lookups in the next cycle onward return the new entry.
  - Writes are unaffected by fades and blanking.
- Frame tick: tick = frame_clk & ~frame_clk_q.
- Fade FSM:
  - IDLE: when fade_start = 1, latch fade_dir and clear the step counter.
    - If L already equals the target (0 for out, FADE_MAX for in), stay IDLE and leave fade_busy low.
    - Otherwise go to FADING; fade_busy = 1 from the next cycle.
  - FADING: each tick increments the step counter. When it reaches FRAMES_PER_STEP, clear it and step L by -1 (out) or +1 (in).
    - When L reaches the target, return to IDLE and drop fade_busy in the same cycle that L updates.
  - fade_start while FADING is ignored.
  - A tick coincident with fade_start in IDLE is not counted.
- L holds its value between fades; a fade-out leaves the screen black until a fade-in completes.
- Reset mid-fade: immediate return to the reset state, including the palette defaults.

Decomposition:
- Package palette_pkg:
  - rgb_t struct {r,g,b};
  - 8-bit default colour constants (PLAYER1, PLAYER2, GROUND, BG_LEFT, BG_RIGHT, HP_DEPLETED, HP, DEFAULT_FILL);
  - function default_entry(idx, ch_w);
  - fade_state_t enum {IDLE, FADING}.
- Sub-module fade_ctrl: frame-tick edge detect, step counter, level L, FSM, and fade_busy. Outputs L to the datapath.

Test Plan:
1. Reset release, color=4, pix_valid=1 held -> two cycles later VGA = 00,68,8B, out_valid = 1; color=13 -> FF,D3,BA.
2. color=63, pix_valid=0 -> VGA = 0,0,0, out_valid = 0 two cycles later; pix_valid toggling every cycle -> output alternates in lockstep, 2-cycle delayed.
3. pal_we addr 5 data 123456, then color=5 -> 12,34,56. Write to addr 5 in the same cycle as its palette read -> that pixel shows FF,7F,50; the next pixel shows 12,34,56.
4. FRAMES_PER_STEP=1, fade_start dir=0, color=5:
   - after 8 ticks L=8 -> VGA = 7F,3F,28;
   - after 16 ticks L=0 -> 0,0,0, fade_busy falls;
   - second fade_start mid-fade leaves L trajectory unchanged.
5. From L=0, fade_start dir=1 -> 16 ticks restore FF,7F,50 and busy drops. fade_start dir=1 at L=FADE_MAX -> fade_busy never asserts.
6. Reset_n pulsed low at L=5 mid-fade after writing entry 5 -> VGA immediately 0, fade_busy 0. After release, color=5 -> FF,7F,50 at full brightness; frame_clk high at release causes no step.
